// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and
// the identity of the stage that owns the memory port.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        IF_DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } grant_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port instruction/data memory between the IF and MEM
// pipeline stages, one transaction at a time, with IF starvation protection.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              mem_done_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              if_stall_o,
    output logic              mem_stall_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic              ram_ready_i,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t   state;
    logic [CNT_W-1:0] starve_cnt;
    logic         if_elig;
    logic         mem_elig;
    logic         starved;
    logic         grant_valid;
    grant_owner_t grant_owner;

    // A stage whose done pulse is showing this cycle has already been served.
    always_comb begin
        if_elig     = if_req_i & ~if_done_o & ~flush_i;
        mem_elig    = mem_req_i & ~mem_done_o;
        starved     = (starve_cnt == STARVE_MAX);
        grant_valid = if_elig | mem_elig;
        grant_owner = (if_elig && (!mem_elig || starved)) ? OWNER_IF : OWNER_MEM;
    end

    assign if_stall_o  = if_req_i & ~if_done_o;
    assign mem_stall_o = mem_req_i & ~mem_done_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            if_done_o   <= 1'b0;
            if_rdata_o  <= '0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= '0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ram_req_o <= 1'b1;
                        if (grant_owner == OWNER_IF) begin
                            state       <= IF_BUSY;
                            ram_we_o    <= 1'b0;
                            ram_addr_o  <= if_addr_i;
                            ram_wdata_o <= '0;
                            starve_cnt  <= '0;
                        end else begin
                            state       <= MEM_BUSY;
                            ram_we_o    <= mem_we_i;
                            ram_addr_o  <= mem_addr_i;
                            ram_wdata_o <= mem_wdata_i;
                            if (!if_req_i)
                                starve_cnt <= '0;
                            else if (!starved)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (!if_req_i) begin
                        starve_cnt <= '0;
                    end
                end
                // A flush arriving with the data returns to IDLE without a done pulse.
                IF_BUSY: begin
                    if (ram_ready_i) begin
                        ram_req_o <= 1'b0;
                        state     <= IDLE;
                        if (!flush_i) begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= ram_rdata_i;
                        end
                    end else if (flush_i) begin
                        state <= IF_DRAIN;
                    end
                end
                IF_DRAIN: begin
                    if (ram_ready_i) begin
                        ram_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                MEM_BUSY: begin
                    if (ram_ready_i) begin
                        ram_req_o  <= 1'b0;
                        state      <= IDLE;
                        mem_done_o <= 1'b1;
                        if (!ram_we_o)
                            mem_rdata_o <= ram_rdata_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared each cycle to a transaction-level model.
module tb_mem_port_arbiter;

    localparam int SL = 2;
    localparam int OWN_NONE = 0;
    localparam int OWN_IF   = 1;
    localparam int OWN_MEM  = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        ram_ready;
    logic [31:0] ram_rdata;

    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        if_stall_o;
    logic        mem_stall_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .if_req_i(if_req),
        .if_addr_i(if_addr),
        .mem_req_i(mem_req),
        .mem_we_i(mem_we),
        .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata),
        .flush_i(flush),
        .if_done_o(if_done_o),
        .if_rdata_o(if_rdata_o),
        .mem_done_o(mem_done_o),
        .mem_rdata_o(mem_rdata_o),
        .if_stall_o(if_stall_o),
        .mem_stall_o(mem_stall_o),
        .ram_req_o(ram_req_o),
        .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_ready_i(ram_ready),
        .ram_rdata_i(ram_rdata)
    );

    // Transaction-level view: who owns the port, whether its fetch was killed,
    // and what each visible output must read this cycle.
    typedef struct packed {
        int          owner;
        bit          killed;
        int          starve;
        logic        ram_req;
        logic        ram_we;
        logic        if_done;
        logic        mem_done;
        logic [31:0] ram_addr;
        logic [31:0] ram_wdata;
        logic [31:0] if_rdata;
        logic [31:0] mem_rdata;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t cur);
        model_t nx;
        bit if_want;
        bit mem_want;
        nx = cur;
        nx.if_done  = 1'b0;
        nx.mem_done = 1'b0;
        if (cur.owner == OWN_NONE) begin
            if_want  = if_req && !cur.if_done && !flush;
            mem_want = mem_req && !cur.mem_done;
            if (if_want && (!mem_want || cur.starve == SL)) begin
                nx.owner    = OWN_IF;
                nx.killed   = 1'b0;
                nx.starve   = 0;
                nx.ram_req  = 1'b1;
                nx.ram_we   = 1'b0;
                nx.ram_addr = if_addr;
            end else if (mem_want) begin
                nx.owner     = OWN_MEM;
                nx.ram_req   = 1'b1;
                nx.ram_we    = mem_we;
                nx.ram_addr  = mem_addr;
                nx.ram_wdata = mem_wdata;
                nx.starve    = if_req ? ((cur.starve < SL) ? cur.starve + 1 : SL) : 0;
            end else if (!if_req) begin
                nx.starve = 0;
            end
        end else if (cur.owner == OWN_IF) begin
            if (ram_ready) begin
                nx.owner   = OWN_NONE;
                nx.ram_req = 1'b0;
                if (!cur.killed && !flush) begin
                    nx.if_done  = 1'b1;
                    nx.if_rdata = ram_rdata;
                end
            end else if (flush) begin
                nx.killed = 1'b1;
            end
        end else begin
            if (ram_ready) begin
                nx.owner    = OWN_NONE;
                nx.ram_req  = 1'b0;
                nx.mem_done = 1'b1;
                if (!cur.ram_we)
                    nx.mem_rdata = ram_rdata;
            end
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i)
            m <= '0;
        else
            m <= model_next(m);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                                 input logic [31:0] ma, input logic [31:0] md, input logic fl,
                                 input logic rr, input logic [31:0] rd);
        @(negedge clk);
        if_req    = ir;
        if_addr   = ia;
        mem_req   = mr;
        mem_we    = mw;
        mem_addr  = ma;
        mem_wdata = md;
        flush     = fl;
        ram_ready = rr;
        ram_rdata = rd;
        #2;
    endtask

    // Per-cycle comparison of every visible output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_i === 1'b1) begin
                checkOutput("ram_req", 32'(ram_req_o), 32'(m.ram_req));
                checkOutput("if_done", 32'(if_done_o), 32'(m.if_done));
                checkOutput("mem_done", 32'(mem_done_o), 32'(m.mem_done));
                checkOutput("if_rdata", if_rdata_o, m.if_rdata);
                checkOutput("mem_rdata", mem_rdata_o, m.mem_rdata);
                checkOutput("if_stall", 32'(if_stall_o), 32'(if_req & ~m.if_done));
                checkOutput("mem_stall", 32'(mem_stall_o), 32'(mem_req & ~m.mem_done));
                if (m.ram_req) begin
                    checkOutput("ram_addr", ram_addr_o, m.ram_addr);
                    checkOutput("ram_we", 32'(ram_we_o), 32'(m.ram_we));
                    if (m.ram_we)
                        checkOutput("ram_wdata", ram_wdata_o, m.ram_wdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [5:0] gbits;
        int         ng;
        logic       prev_req;
        logic       fl_prev;

        rst_i = 1'b0;
        if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; flush = 1'b0; ram_ready = 1'b0; ram_rdata = '0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_ram_req", 32'(ram_req_o), 0);
        checkOutput("rst_if_done", 32'(if_done_o), 0);
        checkOutput("rst_mem_done", 32'(mem_done_o), 0);
        checkOutput("rst_if_rdata", if_rdata_o, 0);
        checkOutput("rst_mem_rdata", mem_rdata_o, 0);
        checkOutput("rst_ram_addr", ram_addr_o, 0);
        @(negedge clk);
        rst_i = 1'b1;

        // IF only fetch with three-cycle memory
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c0_req", 32'(ram_req_o), 0);
        checkOutput("t1_c0_stall", 32'(if_stall_o), 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c1_req", 32'(ram_req_o), 1);
        checkOutput("t1_c1_addr", ram_addr_o, 32'h40);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c2_req", 32'(ram_req_o), 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h8C220004);
        checkOutput("t1_c3_req", 32'(ram_req_o), 1);
        checkOutput("t1_c3_stall", 32'(if_stall_o), 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c4_done", 32'(if_done_o), 1);
        checkOutput("t1_c4_rdata", if_rdata_o, 32'h8C220004);
        checkOutput("t1_c4_stall", 32'(if_stall_o), 0);
        checkOutput("t1_c4_req", 32'(ram_req_o), 0);
        checkOutput("t1_model_rdata", m.if_rdata, 32'h8C220004);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c5_done", 32'(if_done_o), 0);

        // Simultaneous IF and MEM load: MEM first
        applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, 0, 0, 0);
        checkOutput("t2_c0_req", 32'(ram_req_o), 0);
        applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, 0, 1, 32'hA5A50001);
        checkOutput("t2_c1_addr", ram_addr_o, 32'h100);
        checkOutput("t2_c1_we", 32'(ram_we_o), 0);
        applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, 0, 0, 0);
        checkOutput("t2_c2_mdone", 32'(mem_done_o), 1);
        checkOutput("t2_c2_mrdata", mem_rdata_o, 32'hA5A50001);
        checkOutput("t2_c2_req", 32'(ram_req_o), 0);
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 1, 32'h20420008);
        checkOutput("t2_c3_req", 32'(ram_req_o), 1);
        checkOutput("t2_c3_addr", ram_addr_o, 32'h44);
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_c4_idone", 32'(if_done_o), 1);
        checkOutput("t2_c4_irdata", if_rdata_o, 32'h20420008);
        checkOutput("t2_model_mrdata", m.mem_rdata, 32'hA5A50001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store leaves load data untouched
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 1, 32'h0BAD0BAD);
        checkOutput("t3_c1_we", 32'(ram_we_o), 1);
        checkOutput("t3_c1_wdata", ram_wdata_o, 32'hDEADBEEF);
        checkOutput("t3_c1_addr", ram_addr_o, 32'h200);
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("t3_c2_mdone", 32'(mem_done_o), 1);
        checkOutput("t3_c2_mrdata", mem_rdata_o, 32'hA5A50001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_c3_mdone", 32'(mem_done_o), 0);

        // Flush during an outstanding fetch, then a fresh fetch
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t4_c1_addr", ram_addr_o, 32'h48);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_c2_req", 32'(ram_req_o), 1);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 1, 32'hBADBAD00);
        checkOutput("t4_c3_req", 32'(ram_req_o), 1);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_c4_idone", 32'(if_done_o), 0);
        checkOutput("t4_c4_req", 32'(ram_req_o), 0);
        checkOutput("t4_c4_irdata", if_rdata_o, 32'h20420008);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h20080001);
        checkOutput("t4_c5_addr", ram_addr_o, 32'h80);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_c6_idone", 32'(if_done_o), 1);
        checkOutput("t4_c6_irdata", if_rdata_o, 32'h20080001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation: flush blocks IF in every MEM done cycle, so MEM keeps
        // winning until the counter saturates and forces IF through.
        gbits = '0;
        ng = 0;
        prev_req = 1'b0;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h1000;
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_wdata = '0;
            flush = m.mem_done;
            ram_ready = m.ram_req;
            ram_rdata = $urandom;
            #2;
            if (ram_req_o && !prev_req) begin
                gbits = {gbits[4:0], (ram_addr_o == 32'h2000)};
                ng++;
            end
            prev_req = ram_req_o;
        end
        checkOutput("t5_grant_count", ng, 6);
        checkOutput("t5_grant_order", 32'(gbits), 32'h36);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            flush = 1'b0;
            if (m.owner != OWN_MEM) mem_req = 1'b0;
            if (m.owner != OWN_IF) if_req = 1'b0;
            ram_ready = m.ram_req;
            ram_rdata = $urandom;
        end

        // Reset in the middle of a MEM transaction
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0, 0);
        checkOutput("t6_busy_req", 32'(ram_req_o), 1);
        #1;
        rst_i = 1'b0;
        mem_req = 1'b0;
        #1;
        checkOutput("t6_rst_req", 32'(ram_req_o), 0);
        checkOutput("t6_rst_addr", ram_addr_o, 0);
        checkOutput("t6_rst_irdata", if_rdata_o, 0);
        checkOutput("t6_rst_mrdata", mem_rdata_o, 0);
        checkOutput("t6_rst_mdone", 32'(mem_done_o), 0);
        checkOutput("t6_rst_mstall", 32'(mem_stall_o), 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("t6_post_mdone", 32'(mem_done_o), 0);
            checkOutput("t6_post_req", 32'(ram_req_o), 0);
        end

        // Randomized traffic with occasional resets
        fl_prev = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ((cyc % 1000) == 500 || (cyc % 1000) == 501) begin
                rst_i = 1'b0;
                if_req = 1'b0; mem_req = 1'b0; flush = 1'b0; ram_ready = 1'b0;
                fl_prev = 1'b0;
            end else begin
                rst_i = 1'b1;
                if (!if_req) begin
                    if ($urandom_range(0, 1) == 1) begin
                        if_req  = 1'b1;
                        if_addr = $urandom & 32'hFFFC;
                    end
                end else if (m.if_done) begin
                    if_req  = ($urandom_range(0, 1) == 1);
                    if_addr = $urandom & 32'hFFFC;
                end else if (fl_prev) begin
                    if_addr = $urandom & 32'hFFFC;
                end
                if (!mem_req) begin
                    if ($urandom_range(0, 2) == 0) begin
                        mem_req   = 1'b1;
                        mem_we    = ($urandom_range(0, 1) == 1);
                        mem_addr  = $urandom & 32'hFFFC;
                        mem_wdata = $urandom;
                    end
                end else if (m.mem_done) begin
                    mem_req = 1'b0;
                end
                flush     = ($urandom_range(0, 7) == 0);
                ram_ready = m.ram_req && ($urandom_range(0, 1) == 1);
                ram_rdata = $urandom;
                fl_prev   = flush;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipeline CPU. It sequences one memory transaction at a time, returns read data to the owning stage, and generates the per-stage stall signals that the hazard unit ORs into PCWrite/IF-ID-write/pipeline-freeze. A branch-taken flush discards an in-flight fetch result without aborting the memory transaction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive MEM grants allowed while IF waits before IF is forced through (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  IF fetch request, held until if_done_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
- mem_req_i  in  1  MEM-stage request (MemRead|MemWrite), held until mem_done_o
- mem_we_i  in  1  1 = store
- mem_addr_i  in  ADDR_W  load/store address
- mem_wdata_i  in  DATA_W  store data
- flush_i  in  1  branch taken (PCSrc); kills outstanding/pending fetch
- if_done_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  DATA_W  fetched instruction
- mem_done_o  out  1  one-cycle pulse, load/store complete
- mem_rdata_o  out  DATA_W  load data
- if_stall_o  out  1  if_req_i & ~if_done_o (combinational)
- mem_stall_o  out  1  mem_req_i & ~mem_done_o (combinational)
- ram_req_o  out  1  memory request, held until ram_ready_i
- ram_we_o  out  1  memory write enable
- ram_addr_o  out  ADDR_W  memory address
- ram_wdata_o  out  DATA_W  memory write data
- ram_ready_i  in  1  memory completes transaction this cycle
- ram_rdata_i  in  DATA_W  read data, valid when ram_ready_i

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY, IF_DRAIN.
- IDLE: evaluate requests (requesters whose done_o is high this cycle are ignored). MEM wins over IF unless starve count == STARVE_LIMIT and both request, then IF wins. IF not granted in a cycle with flush_i=1. Grant loads ram_* registers, ram_req_o=1, go to *_BUSY.
- IF_BUSY: on ram_ready_i capture ram_rdata_i into if_rdata_o, pulse if_done_o next cycle, drop ram_req_o, go IDLE. flush_i=1 (before or with ram_ready_i) -> IF_DRAIN (or straight IDLE if ram_ready_i same cycle) with no if_done_o.
- IF_DRAIN: hold ram_req_o until ram_ready_i, discard data, go IDLE.
- MEM_BUSY: on ram_ready_i, pulse mem_done_o next cycle; loads update mem_rdata_o, stores leave it unchanged. flush_i ignored.
- Starve counter: +1 per MEM grant while if_req_i=1 (saturates at STARVE_LIMIT); cleared on IF grant or when if_req_i=0 in IDLE.
- Reset (any time, mid-transaction included): state IDLE, all outputs and counter 0; memory must be reset concurrently.

## Timing
- Request seen in IDLE at cycle N -> ram_req_o high from N+1; ram_ready_i at cycle M≥N+1 -> done_o and rdata at M+1, state IDLE at M+1, next grant evaluated at M+1, ram_req_o again at M+2 earliest.
- Minimum request-to-done latency 2 cycles; one transaction per 2 cycles max.
- ram_addr_o/ram_we_o/ram_wdata_o stable for the whole ram_req_o window.
- done_o pulses exactly one cycle; rdata_o hold until next capture.

## Structure
- Shared package: state encoding (2-bit enum IDLE=0, IF_BUSY=1, MEM_BUSY=2, IF_DRAIN=3), grant-owner constants.
- Single flat module; no sub-module needed (counter and FSM are small).

## Test plan
- IF only, addr 0x40, ram_ready_i at cycle 3 with 0x8C220004 -> ram_req_o cycles 1–3, if_done_o and if_rdata_o=0x8C220004 at cycle 4, if_stall_o high cycles 0–3.
- IF 0x44 and MEM load 0x100 same cycle, immediate ready -> MEM served first (ram_addr_o=0x100), mem_done_o cycle 2, IF granted cycle 2, if_done_o cycle 4.
- Store 0x200 data 0xDEADBEEF -> ram_we_o=1, ram_wdata_o=0xDEADBEEF, mem_done_o pulse, mem_rdata_o unchanged.
- flush_i during IF_BUSY at 0x48, ready 2 cycles later -> no if_done_o, IDLE after ready; next fetch 0x80 completes normally.
- STARVE_LIMIT=2, continuous MEM and IF requests -> grant order M,M,I,M,M,I.
- rst_i low while MEM_BUSY -> all outputs 0 immediately, no done_o after release.
